// File: rtl/uart_controller_read_if.sv
// Serial receive bus: the asynchronous line in, the received byte and status pulses out.
interface uart_controller_read_if;
    logic       uart_pin;
    logic [7:0] read_data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output uart_pin,
        input  read_data,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  uart_pin,
        output read_data,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_controller_read.sv
// UART 8N1 receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_controller_read #(
    parameter int baud_rate      = 921600,
    parameter int sys_clock_freq = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_controller_read_if.slave  bus
);

    localparam int BIT   = sys_clock_freq / baud_rate;
    localparam int HALF  = BIT / 2;
    localparam int CNT_W = (BIT > 1) ? $clog2(BIT) : 1;

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so every decision slips one cycle.
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF);
`else
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF - 1);
`endif
    localparam logic [CNT_W-1:0] BIT_PT = CNT_W'(BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_read_data;
    logic             r_data_valid;
    logic             r_frame_error;
    logic             r_busy;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic             w_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.uart_pin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_d1;
    logic r_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1 <= 1'b1;
            r_d2 <= 1'b1;
        end else begin
            r_d1 <= w_rx_s;
            r_d2 <= r_d1;
        end
    end

    assign w_bit = (w_rx_s & r_d1) | (w_rx_s & r_d2) | (r_d1 & r_d2);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_read_data   <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == START_PT) begin
                        r_cnt <= '0;
                        if (w_bit) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_PT) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == BIT_PT) begin
                        r_cnt <= '0;
                        if (w_bit) begin
                            r_read_data  <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A broken frame must not re-trigger on the still-low line.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_data   = r_read_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

endmodule
